// File: rtl/poly_square_voice_mixer_pkg.sv
// rtl/poly_square_voice_mixer_pkg.sv - shared types and constants for the square-wave voice mixer
package poly_square_voice_mixer_pkg;

    // Envelope states of one voice
    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_t;

    // Default geometry of the mixer
    localparam int DEF_NUM_VOICES   = 24;
    localparam int DEF_PERIOD_W     = 17;
    localparam int DEF_AMP_W        = 8;
    localparam int DEF_ENV_TICK_DIV = 50000;
    localparam int DEF_OUT_W        = 32;
    localparam int DEF_OUT_SHIFT    = 16;

    // Half-period counts (clk cycles per half wave) for C4..B5 at a 50 MHz clock
    localparam int unsigned NOTE_C4 = 95556;
    localparam int unsigned NOTE_D4 = 85131;
    localparam int unsigned NOTE_E4 = 75843;
    localparam int unsigned NOTE_F4 = 71586;
    localparam int unsigned NOTE_G4 = 63776;
    localparam int unsigned NOTE_A4 = 56818;
    localparam int unsigned NOTE_B4 = 50619;
    localparam int unsigned NOTE_C5 = 47778;
    localparam int unsigned NOTE_D5 = 42566;
    localparam int unsigned NOTE_E5 = 37921;
    localparam int unsigned NOTE_F5 = 35793;
    localparam int unsigned NOTE_G5 = 31888;
    localparam int unsigned NOTE_A5 = 28409;
    localparam int unsigned NOTE_B5 = 25310;

endpackage

// File: rtl/poly_square_voice_mixer_if.sv
// rtl/poly_square_voice_mixer_if.sv - control and sample bus of the square-wave voice mixer
interface poly_square_voice_mixer_if #(
    parameter int NUM_VOICES = 24,
    parameter int PERIOD_W   = 17,
    parameter int AMP_W      = 8,
    parameter int OUT_W      = 32
);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    logic [NUM_VOICES-1:0]          gate;
    logic [NUM_VOICES*PERIOD_W-1:0] half_period;
    logic [AMP_W-1:0]               attack_step;
    logic [AMP_W-1:0]               release_step;
    logic signed [OUT_W-1:0]        out_sample;
    logic [CNT_W-1:0]               active_voices;

    // Key/playback decode side
    modport master (
        output gate, half_period, attack_step, release_step,
        input  out_sample, active_voices
    );

    // Synthesiser side
    modport slave (
        input  gate, half_period, attack_step, release_step,
        output out_sample, active_voices
    );

endinterface

// File: rtl/poly_square_voice_mixer_voice.sv
// rtl/poly_square_voice_mixer_voice.sv - one square-wave tone channel with attack/release envelope
module poly_square_voice_mixer_voice
    import poly_square_voice_mixer_pkg::*;
#(
    parameter int PERIOD_W = 17,
    parameter int AMP_W    = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    i_gate,
    input  logic [PERIOD_W-1:0]     i_half_period,
    input  logic [AMP_W-1:0]        i_attack_step,
    input  logic [AMP_W-1:0]        i_release_step,
    input  logic                    i_env_tick,
    output logic signed [AMP_W:0]   o_contrib,
    output logic                    o_active
);

    localparam logic [AMP_W-1:0] AMP_MAX = '1;

    logic                  r_gate_q;
    logic [PERIOD_W-1:0]   r_cnt;
    logic                  r_lvl;
    env_state_t            r_state;
    logic [AMP_W-1:0]      r_amp;

    logic                  w_rise;
    logic                  w_mute;
    logic [AMP_W:0]        w_amp_up;
    logic signed [AMP_W:0] w_mag;

    assign w_rise   = i_gate & ~r_gate_q;
    assign w_mute   = (i_half_period == '0);
    // One extra bit so the attack sum can be clamped instead of wrapping
    assign w_amp_up = {1'b0, r_amp} + {1'b0, i_attack_step};
    assign w_mag    = signed'({1'b0, r_amp});
    assign o_active = (r_state != ENV_IDLE);

    // Gate history for key-down edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_gate_q <= 1'b0;
        end else begin
            r_gate_q <= i_gate;
        end
    end

    // Phase counter: restart on key-down, park while muted, flip level at end of each half period
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_lvl <= 1'b1;
        end else if (w_rise || w_mute) begin
            r_cnt <= '0;
            r_lvl <= 1'b1;
        end else if (r_cnt >= i_half_period) begin
            // >= so a period shortened below the running count ends the half wave at once
            r_cnt <= '0;
            r_lvl <= ~r_lvl;
        end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
        end
    end

    // Envelope: key-down starts attack, key-up always wins over a pending amplitude step
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ENV_IDLE;
            r_amp   <= '0;
        end else begin
            case (r_state)
                ENV_IDLE: begin
                    r_amp <= '0;
                    if (w_rise) begin
                        r_state <= ENV_ATTACK;
                    end
                end
                ENV_ATTACK: begin
                    if (!i_gate) begin
                        r_state <= ENV_RELEASE;
                    end else if (!w_rise) begin
                        if ((i_attack_step == '0) ||
                            (i_env_tick && (w_amp_up >= {1'b0, AMP_MAX}))) begin
                            r_amp   <= AMP_MAX;
                            r_state <= ENV_SUSTAIN;
                        end else if (i_env_tick) begin
                            r_amp <= w_amp_up[AMP_W-1:0];
                        end
                    end
                end
                ENV_SUSTAIN: begin
                    r_amp <= AMP_MAX;
                    if (!i_gate) begin
                        r_state <= ENV_RELEASE;
                    end
                end
                ENV_RELEASE: begin
                    if (w_rise) begin
                        // Retrigger keeps the current amplitude to avoid a click
                        r_state <= ENV_ATTACK;
                    end else if ((i_release_step == '0) || (r_amp == '0) ||
                                 (i_env_tick && (r_amp <= i_release_step))) begin
                        r_amp   <= '0;
                        r_state <= ENV_IDLE;
                    end else if (i_env_tick) begin
                        r_amp <= r_amp - i_release_step;
                    end
                end
                default: begin
                    r_state <= ENV_IDLE;
                    r_amp   <= '0;
                end
            endcase
        end
    end

    // Signed contribution: +amp on the high half wave, -amp on the low one, silent when muted
    always_comb begin
        o_contrib = '0;
        if (!w_mute) begin
            o_contrib = r_lvl ? w_mag : -w_mag;
        end
    end

endmodule

// File: rtl/poly_square_voice_mixer.sv
// rtl/poly_square_voice_mixer.sv - polyphonic square-wave synthesiser with saturated mix output
module poly_square_voice_mixer
    import poly_square_voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES   = DEF_NUM_VOICES,
    parameter int PERIOD_W     = DEF_PERIOD_W,
    parameter int AMP_W        = DEF_AMP_W,
    parameter int ENV_TICK_DIV = DEF_ENV_TICK_DIV,
    parameter int OUT_W        = DEF_OUT_W,
    parameter int OUT_SHIFT    = DEF_OUT_SHIFT
) (
    input  logic                     clk,
    input  logic                     resetn,
    poly_square_voice_mixer_if.slave bus
);

    localparam int CNT_W   = $clog2(NUM_VOICES + 1);
    localparam int SUM_W   = AMP_W + 1 + $clog2(NUM_VOICES);
    localparam int SHIFT_W = SUM_W + OUT_SHIFT;
    // One guard bit above whichever is wider, so the shifted sum never overflows before clamping
    localparam int WIDE_W  = ((SHIFT_W > OUT_W) ? SHIFT_W : OUT_W) + 1;
    localparam int PRE_W   = $clog2(ENV_TICK_DIV + 1);

    localparam logic signed [WIDE_W-1:0] SAT_MAX =
        {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN =
        {{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [PRE_W-1:0]           r_presc;
    logic signed [OUT_W-1:0]    r_out_sample;
    logic [CNT_W-1:0]           r_active_voices;

    logic                       w_env_tick;
    logic signed [AMP_W:0]      w_contrib [NUM_VOICES];
    logic [NUM_VOICES-1:0]      w_active;
    logic signed [SUM_W-1:0]    w_sum;
    logic signed [WIDE_W-1:0]   w_scaled;
    logic signed [OUT_W-1:0]    w_sat;
    logic [CNT_W-1:0]           w_count;

    assign w_env_tick = (r_presc == PRE_W'(ENV_TICK_DIV - 1));

    // Free-running envelope prescaler shared by all voices
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
        end else if (w_env_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        poly_square_voice_mixer_voice #(
            .PERIOD_W (PERIOD_W),
            .AMP_W    (AMP_W)
        ) u_voice (
            .clk            (clk),
            .resetn         (resetn),
            .i_gate         (bus.gate[g]),
            .i_half_period  (bus.half_period[g*PERIOD_W +: PERIOD_W]),
            .i_attack_step  (bus.attack_step),
            .i_release_step (bus.release_step),
            .i_env_tick     (w_env_tick),
            .o_contrib      (w_contrib[g]),
            .o_active       (w_active[g])
        );
    end

    // Sign-extended sum of all voice contributions
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_sum = w_sum + SUM_W'(w_contrib[i]);
        end
    end

    assign w_scaled = WIDE_W'(w_sum) <<< OUT_SHIFT;

    // Clamp the scaled mix into the signed output range
    always_comb begin
        w_sat = w_scaled[OUT_W-1:0];
        if (w_scaled > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_W-1:0];
        end else if (w_scaled < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_W-1:0];
        end
    end

    // Number of voices currently sounding or releasing
    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_count = w_count + CNT_W'(w_active[i]);
        end
    end

    // Output registers; asynchronous reset silences the sample path immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_sample    <= '0;
            r_active_voices <= '0;
        end else begin
            r_out_sample    <= w_sat;
            r_active_voices <= w_count;
        end
    end

    assign bus.out_sample    = r_out_sample;
    assign bus.active_voices = r_active_voices;

endmodule
